// File: rtl/lvds_frame_gen.sv
// Test-pattern frame generator feeding the 2-lane LVDS serializer.
// Emits sync word, then LINES lines of LINE_LEN active words each followed by GAP_LEN idle words.
module lvds_frame_gen #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned LINE_LEN = 256,
    parameter int unsigned LINES    = 16,
    parameter int unsigned GAP_LEN  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cfg_valid,
    input  logic [1:0]        cfg_pattern,
    input  logic [DATA_W-1:0] cfg_seed,
    output logic              cfg_ready,
    input  logic              word_ready,
    output logic [DATA_W-1:0] lane0_data,
    output logic [DATA_W-1:0] lane1_data,
    output logic              data_valid,
    output logic              sync,
    output logic [15:0]       frame_cnt,
    output logic              busy
);

    localparam int unsigned COL_W  = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int unsigned LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int unsigned GAP_W  = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [DATA_W-1:0] SYNC_WORD = DATA_W'(8'hBC);

    localparam logic [1:0] PAT_COUNTER = 2'd0;
    localparam logic [1:0] PAT_PRBS    = 2'd1;
    localparam logic [1:0] PAT_FIXED   = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_ACTIVE, S_GAP} state_t;

    state_t              r_state;
    logic [COL_W-1:0]    r_col;
    logic [LINE_W-1:0]   r_line;
    logic [GAP_W-1:0]    r_gap;
    logic [1:0]          r_pattern;
    logic [DATA_W-1:0]   r_seed;
    logic [6:0]          r_lfsr0;
    logic [6:0]          r_lfsr1;
    logic [DATA_W-1:0]   r_lane0;
    logic [DATA_W-1:0]   r_lane1;
    logic                r_valid;
    logic                r_sync;
    logic                r_busy;
    logic                r_cfg_ready;
    logic [15:0]         r_frame_cnt;

    logic [6:0]          w_seed0;
    logic [6:0]          w_seed1_raw;
    logic [6:0]          w_seed1;
    logic [6:0]          w_cur0;
    logic [6:0]          w_cur1;
    logic [COL_W-1:0]    w_next_col;
    logic [LINE_W-1:0]   w_next_line;
    logic [DATA_W-1:0]   w_pat0;
    logic [DATA_W-1:0]   w_pat1;
    logic                w_last_col;
    logic                w_last_gap;
    logic                w_last_line;

    // x^7 + x^6 + 1, shifting left
    function automatic logic [6:0] prbs_step(input logic [6:0] x);
        return {x[5:0], x[6] ^ x[5]};
    endfunction

    assign w_seed0     = (r_seed[6:0] == 7'h00) ? 7'h01 : r_seed[6:0];
    assign w_seed1_raw = w_seed0 ^ 7'h55;
    assign w_seed1     = (w_seed1_raw == 7'h00) ? 7'h01 : w_seed1_raw;

    // The LFSR registers hold the value for the next active word; the first word of a frame uses the seed.
    assign w_cur0 = (r_state == S_SYNC) ? w_seed0 : r_lfsr0;
    assign w_cur1 = (r_state == S_SYNC) ? w_seed1 : r_lfsr1;

    assign w_last_col  = (r_col == COL_W'(LINE_LEN - 1));
    assign w_last_gap  = (r_gap == GAP_W'(GAP_LEN - 1));
    assign w_last_line = (r_line == LINE_W'(LINES - 1));

    // Column/line of the active word that would be loaded on this word_ready edge
    always_comb begin
        w_next_col  = '0;
        w_next_line = r_line;
        case (r_state)
            S_SYNC:   w_next_line = '0;
            S_ACTIVE: w_next_col  = r_col + COL_W'(1);
            S_GAP:    w_next_line = r_line + LINE_W'(1);
            default:  w_next_col  = '0;
        endcase
    end

    always_comb begin
        w_pat0 = DATA_W'(w_next_line);
        w_pat1 = DATA_W'(w_next_col);
        case (r_pattern)
            PAT_COUNTER: begin
                w_pat0 = DATA_W'(w_next_col);
                w_pat1 = ~DATA_W'(w_next_col);
            end
            PAT_PRBS: begin
                w_pat0 = DATA_W'(w_cur0);
                w_pat1 = DATA_W'(w_cur1);
            end
            PAT_FIXED: begin
                w_pat0 = r_seed;
                w_pat1 = ~r_seed;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_line      <= '0;
            r_gap       <= '0;
            r_pattern   <= PAT_COUNTER;
            r_seed      <= '0;
            r_lfsr0     <= 7'h01;
            r_lfsr1     <= 7'h01;
            r_lane0     <= '0;
            r_lane1     <= '0;
            r_valid     <= 1'b0;
            r_sync      <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_frame_cnt <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        r_pattern <= cfg_pattern;
                        r_seed    <= cfg_seed;
                    end
                    if (enable) begin
                        r_state     <= S_SYNC;
                        r_lane0     <= SYNC_WORD;
                        r_lane1     <= SYNC_WORD;
                        r_sync      <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cfg_ready <= 1'b0;
                    end
                end
                S_SYNC: begin
                    if (word_ready) begin
                        r_state <= S_ACTIVE;
                        r_col   <= '0;
                        r_line  <= '0;
                        r_sync  <= 1'b0;
                        r_valid <= 1'b1;
                        r_lane0 <= w_pat0;
                        r_lane1 <= w_pat1;
                        r_lfsr0 <= prbs_step(w_cur0);
                        r_lfsr1 <= prbs_step(w_cur1);
                    end
                end
                S_ACTIVE: begin
                    if (word_ready) begin
                        if (w_last_col) begin
                            r_state <= S_GAP;
                            r_gap   <= '0;
                            r_valid <= 1'b0;
                            r_lane0 <= '0;
                            r_lane1 <= '0;
                        end else begin
                            r_col   <= w_next_col;
                            r_lane0 <= w_pat0;
                            r_lane1 <= w_pat1;
                            r_lfsr0 <= prbs_step(w_cur0);
                            r_lfsr1 <= prbs_step(w_cur1);
                        end
                    end
                end
                S_GAP: begin
                    if (word_ready) begin
                        if (!w_last_gap) begin
                            r_gap <= r_gap + GAP_W'(1);
                        end else if (!w_last_line) begin
                            r_state <= S_ACTIVE;
                            r_line  <= w_next_line;
                            r_col   <= '0;
                            r_valid <= 1'b1;
                            r_lane0 <= w_pat0;
                            r_lane1 <= w_pat1;
                            r_lfsr0 <= prbs_step(w_cur0);
                            r_lfsr1 <= prbs_step(w_cur1);
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            if (enable) begin
                                r_state <= S_SYNC;
                                r_lane0 <= SYNC_WORD;
                                r_lane1 <= SYNC_WORD;
                                r_sync  <= 1'b1;
                            end else begin
                                r_state     <= S_IDLE;
                                r_busy      <= 1'b0;
                                r_cfg_ready <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready  = r_cfg_ready;
    assign lane0_data = r_lane0;
    assign lane1_data = r_lane1;
    assign data_valid = r_valid;
    assign sync       = r_sync;
    assign frame_cnt  = r_frame_cnt;
    assign busy       = r_busy;

endmodule
